// File: rtl/pipe_ctrl_if.sv
// Hazard/control bundle between the pipeline datapath and its controller.
// The controller takes the slave view; the datapath (or a bench) takes the master view.
interface pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             load_use;
    logic             redirect;
    logic             mem_req;
    logic             mem_ack;
    logic             halt_req;
    logic             resume;
    logic             pc_en;
    logic             pc_sel_redirect;
    logic             stall_fd;
    logic             stall_de;
    logic             stall_em;
    logic             flush_fd;
    logic             bubble_de;
    logic             bubble_mw;
    logic             halted;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output load_use, redirect, mem_req, mem_ack, halt_req, resume,
        input  pc_en, pc_sel_redirect, stall_fd, stall_de, stall_em, flush_fd,
               bubble_de, bubble_mw, halted, state_o, stall_cnt, flush_cnt
    );

    modport slave (
        input  load_use, redirect, mem_req, mem_ack, halt_req, resume,
        output pc_en, pc_sel_redirect, stall_fd, stall_de, stall_em, flush_fd,
               bubble_de, bubble_mw, halted, state_o, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: memory-wait stalls, redirect flushes, load-use bubbles,
// halt/drain sequencing and saturating stall/flush performance counters.
module pipe_ctrl #(
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = 3
) (
    input  logic         clk,
    input  logic         reset,
    pipe_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } state_t;

    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYC - 1);

    state_t           state_reg, state_next;
    logic [DW-1:0]    drain_reg, drain_next;
    logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

    logic mem_hold;
    logic pc_en, pc_sel_redirect, stall_fd, stall_de, stall_em;
    logic flush_fd, bubble_de, bubble_mw, halted;
    logic stall_inc;

    assign mem_hold = bus.mem_req && !bus.mem_ack;

    always_comb begin
        state_next      = state_reg;
        drain_next      = drain_reg;
        pc_en           = 1'b0;
        pc_sel_redirect = 1'b0;
        stall_fd        = 1'b0;
        stall_de        = 1'b0;
        stall_em        = 1'b0;
        flush_fd        = 1'b0;
        bubble_de       = 1'b0;
        bubble_mw       = 1'b0;
        halted          = 1'b0;
        case (state_reg)
            RUN, MEM_WAIT: begin
                // MEM_WAIT only listens to mem_ack; RUN enters the wait on an unacked request
                if ((state_reg == RUN && mem_hold) || (state_reg == MEM_WAIT && !bus.mem_ack)) begin
                    stall_fd   = 1'b1;
                    stall_de   = 1'b1;
                    stall_em   = 1'b1;
                    bubble_mw  = 1'b1;
                    state_next = MEM_WAIT;
                end else begin
                    if (bus.redirect) begin
                        pc_en           = 1'b1;
                        pc_sel_redirect = 1'b1;
                        flush_fd        = 1'b1;
                        bubble_de       = 1'b1;
                    end else if (bus.load_use) begin
                        stall_fd  = 1'b1;
                        bubble_de = 1'b1;
                    end else begin
                        pc_en = 1'b1;
                    end
                    if (bus.halt_req) begin
                        state_next = DRAIN;
                        drain_next = DRAIN_LOAD;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            DRAIN: begin
                flush_fd = 1'b1;
                if (mem_hold) begin
                    stall_fd  = 1'b1;
                    stall_de  = 1'b1;
                    stall_em  = 1'b1;
                    bubble_mw = 1'b1;
                end else if (drain_reg == '0) begin
                    state_next = HALTED;
                end else begin
                    drain_next = drain_reg - DW'(1);
                end
            end
            HALTED: begin
                stall_fd = 1'b1;
                stall_de = 1'b1;
                stall_em = 1'b1;
                halted   = 1'b1;
                if (bus.resume) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    assign stall_inc = ((state_reg == RUN) || (state_reg == MEM_WAIT)) && !pc_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= RUN;
            drain_reg     <= '0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            drain_reg <= drain_next;
            if (stall_inc && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end
            if (pc_sel_redirect && (flush_cnt_reg != '1)) begin
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign bus.pc_en           = pc_en;
    assign bus.pc_sel_redirect = pc_sel_redirect;
    assign bus.stall_fd        = stall_fd;
    assign bus.stall_de        = stall_de;
    assign bus.stall_em        = stall_em;
    assign bus.flush_fd        = flush_fd;
    assign bus.bubble_de       = bubble_de;
    assign bus.bubble_mw       = bubble_mw;
    assign bus.halted          = halted;
    assign bus.state_o         = state_reg;
    assign bus.stall_cnt       = stall_cnt_reg;
    assign bus.flush_cnt       = flush_cnt_reg;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vector table, hand sequences for drain/reset/saturation,
// and randomized traffic against a rule-level reference model.
module tb_pipe_ctrl;
    localparam int CW   = 4;
    localparam int DCYC = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    pipe_ctrl_if #(.CNT_W(CW)) bus ();

    pipe_ctrl #(.CNT_W(CW), .DRAIN_CYC(DCYC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // inputs packed {load_use, redirect, mem_req, mem_ack, halt_req, resume}
    // controls packed {pc_en, sel, stall_fd, stall_de, stall_em, flush_fd, bubble_de, bubble_mw, halted}
    typedef struct {
        logic [5:0] in;
        logic [8:0] ctl;
        logic [1:0] st;
        int         sc;
        int         fc;
    } vec_t;

    vec_t vec [18];

    int m_mode, m_dl, m_sc, m_fc;

    function automatic logic [8:0] act_ctl();
        return {bus.pc_en, bus.pc_sel_redirect, bus.stall_fd, bus.stall_de, bus.stall_em,
                bus.flush_fd, bus.bubble_de, bus.bubble_mw, bus.halted};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic drive(input logic [5:0] in);
        {bus.load_use, bus.redirect, bus.mem_req, bus.mem_ack, bus.halt_req, bus.resume} = in;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(6'b0);
        tick();
        tick();
        reset = 1'b0;
        m_mode = 0; m_dl = 0; m_sc = 0; m_fc = 0;
    endtask

    // Reference: expected controls and next state from the behavioural rules.
    task automatic model_eval(input logic [5:0] in, output logic [8:0] ctl,
                              output int nmode, output int ndl);
        bit lu, rd, mq, ma, hr, rs, waiting, issuing;
        {lu, rd, mq, ma, hr, rs} = in;
        waiting = ((m_mode == 0 || m_mode == 2) && mq && !ma) || (m_mode == 1 && !ma);
        issuing = !waiting && (m_mode <= 1);
        ctl[8] = issuing && (rd || !lu);
        ctl[7] = issuing && rd;
        ctl[6] = waiting || (m_mode == 3) || (issuing && !rd && lu);
        ctl[5] = waiting || (m_mode == 3);
        ctl[4] = waiting || (m_mode == 3);
        ctl[3] = (issuing && rd) || (m_mode == 2);
        ctl[2] = issuing && (rd || lu);
        ctl[1] = waiting;
        ctl[0] = (m_mode == 3);
        nmode = m_mode;
        ndl   = m_dl;
        if (waiting) begin
            nmode = (m_mode == 2) ? 2 : 1;
        end else if (m_mode <= 1) begin
            nmode = hr ? 2 : 0;
            if (hr) ndl = DCYC - 1;
        end else if (m_mode == 2) begin
            if (m_dl == 0) nmode = 3;
            else ndl = m_dl - 1;
        end else if (rs) begin
            nmode = 0;
        end
    endtask

    initial begin
        logic [8:0] ectl;
        int nm, nd;
        reset = 1'b1;
        drive(6'b0);

        vec[0]  = '{6'b000000, 9'b100000000, 2'd0, 0, 0};
        vec[1]  = '{6'b100000, 9'b001000100, 2'd0, 0, 0};
        vec[2]  = '{6'b000000, 9'b100000000, 2'd0, 1, 0};
        vec[3]  = '{6'b110000, 9'b110001100, 2'd0, 1, 0};
        vec[4]  = '{6'b000000, 9'b100000000, 2'd0, 1, 1};
        vec[5]  = '{6'b001000, 9'b001110010, 2'd0, 1, 1};
        vec[6]  = '{6'b011000, 9'b001110010, 2'd1, 2, 1};
        vec[7]  = '{6'b101000, 9'b001110010, 2'd1, 3, 1};
        vec[8]  = '{6'b001100, 9'b100000000, 2'd1, 4, 1};
        vec[9]  = '{6'b000000, 9'b100000000, 2'd0, 4, 1};
        vec[10] = '{6'b010010, 9'b110001100, 2'd0, 4, 1};
        vec[11] = '{6'b000010, 9'b000001000, 2'd2, 4, 2};
        vec[12] = '{6'b001010, 9'b001111010, 2'd2, 4, 2};
        vec[13] = '{6'b000010, 9'b000001000, 2'd2, 4, 2};
        vec[14] = '{6'b010000, 9'b000001000, 2'd2, 4, 2};
        vec[15] = '{6'b000010, 9'b001110001, 2'd3, 4, 2};
        vec[16] = '{6'b000001, 9'b001110001, 2'd3, 4, 2};
        vec[17] = '{6'b000000, 9'b100000000, 2'd0, 4, 2};

        do_reset();
        for (int i = 0; i < 18; i++) begin
            drive(vec[i].in);
            @(negedge clk);
            check($sformatf("vec%0d ctl", i), int'(act_ctl()), int'(vec[i].ctl));
            check($sformatf("vec%0d state", i), int'(bus.state_o), int'(vec[i].st));
            check($sformatf("vec%0d stall_cnt", i), int'(bus.stall_cnt), vec[i].sc);
            check($sformatf("vec%0d flush_cnt", i), int'(bus.flush_cnt), vec[i].fc);
            $display("vec %0d in=%b ctl=%b st=%0d", i, vec[i].in, act_ctl(), bus.state_o);
            tick();
        end

        // one-cycle halt request: three DRAIN cycles, then HALTED, then resume
        do_reset();
        drive(6'b000010);
        tick();
        drive(6'b000000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("drain%0d state", i), int'(bus.state_o), 2);
            tick();
        end
        @(negedge clk);
        check("halted flag", int'(bus.halted), 1);
        drive(6'b000001);
        tick();
        drive(6'b000000);
        @(negedge clk);
        check("resume state", int'(bus.state_o), 0);
        check("resume pc_en", int'(bus.pc_en), 1);
        $display("halt/resume sequence done");

        // reset while waiting on memory
        do_reset();
        drive(6'b001000);
        tick();
        tick();
        @(negedge clk);
        check("pre-reset state", int'(bus.state_o), 1);
        check("pre-reset stall_cnt", int'(bus.stall_cnt), 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(6'b000000);
        @(negedge clk);
        check("post-reset state", int'(bus.state_o), 0);
        check("post-reset stall_cnt", int'(bus.stall_cnt), 0);
        check("post-reset pc_en", int'(bus.pc_en), 1);
        $display("reset during MEM_WAIT done");

        // counter saturation
        do_reset();
        drive(6'b100000);
        repeat (14) tick();
        @(negedge clk);
        check("stall_cnt at 14", int'(bus.stall_cnt), 14);
        repeat (6) tick();
        drive(6'b010000);
        @(negedge clk);
        check("stall_cnt saturated", int'(bus.stall_cnt), CMAX);
        repeat (20) tick();
        drive(6'b000000);
        @(negedge clk);
        check("flush_cnt saturated", int'(bus.flush_cnt), CMAX);
        check("stall_cnt held", int'(bus.stall_cnt), CMAX);
        $display("saturation sequence done");

        // randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [5:0] in;
            bit rst_now;
            in[5] = ($urandom_range(0, 3) == 0);
            in[4] = ($urandom_range(0, 5) == 0);
            in[3] = ($urandom_range(0, 2) == 0);
            in[2] = ($urandom_range(0, 1) == 0);
            in[1] = ($urandom_range(0, 11) == 0);
            in[0] = ($urandom_range(0, 3) == 0);
            rst_now = ($urandom_range(0, 79) == 0);
            drive(in);
            reset = rst_now;
            model_eval(in, ectl, nm, nd);
            @(negedge clk);
            check($sformatf("rnd%0d ctl", i), int'(act_ctl()), int'(ectl));
            check($sformatf("rnd%0d state", i), int'(bus.state_o), m_mode);
            check($sformatf("rnd%0d stall_cnt", i), int'(bus.stall_cnt), m_sc);
            check($sformatf("rnd%0d flush_cnt", i), int'(bus.flush_cnt), m_fc);
            $display("rnd %0d in=%b rst=%0d ctl=%b st=%0d", i, in, rst_now, act_ctl(), bus.state_o);
            tick();
            if (rst_now) begin
                m_mode = 0; m_dl = 0; m_sc = 0; m_fc = 0;
            end else begin
                if (m_mode <= 1 && !ectl[8] && m_sc < CMAX) m_sc++;
                if (ectl[7] && m_fc < CMAX) m_fc++;
                m_mode = nm;
                m_dl   = nd;
            end
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
